// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first.
//
// Each cycle, one full-subtractor cell (two half-subtractor stages plus an OR on
// their borrows) processes bit 0 of the operand shift registers. The borrow is held
// in a flop between cycles. The result is registered and held for downstream logic.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset, priority over everything
//   start       request an operation; only sampled in idle
//   a, b        minuend / subtrahend, captured on the accepting edge
//   busy        high while an operation is in flight (WIDTH cycles)
//   done        one-cycle pulse when diff/borrow_out are updated
//   diff        registered (a - b) mod 2^WIDTH
//   borrow_out  registered final borrow, 1 iff a < b
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             bw_q, bw_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    // Full-subtractor cell on the current LSBs.
    logic hs1_diff, hs1_borrow;
    logic bit_diff, hs2_borrow;
    logic bnext;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        hs1_diff   = a_sh_q[0] ^ b_sh_q[0];
        hs1_borrow = ~a_sh_q[0] & b_sh_q[0];
        bit_diff   = hs1_diff ^ bw_q;
        hs2_borrow = ~hs1_diff & bw_q;
        bnext      = hs1_borrow | hs2_borrow;
        // New bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB result.
        res_next   = {bit_diff, res_sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        bw_d     = bw_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    bw_d     = 1'b0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                res_sh_d = res_next;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                bw_d     = bnext;
                count_d  = count_q + CntW'(1);
                if (count_q == CntW'(WIDTH - 1)) begin
                    diff_d   = res_next;
                    borrow_d = bnext;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            bw_q     <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            bw_q     <= bw_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor against a
// plain-arithmetic reference (diff = a - b truncated, borrow = a < b).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Last completed result, which the outputs must hold between completions.
    logic [W-1:0] last_diff;
    logic         last_borrow;

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Caller is at a negedge. Presents start with av/bv, then walks through the
    // operation checking busy/done/holding outputs each cycle. If inject is in
    // 1..W, a conflicting start is raised at that cycle and must be ignored.
    // Returns at the negedge of the done cycle with start left low.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int inject);
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        exp_diff   = av - bv;
        exp_borrow = (av < bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k <= W) begin
                check("busy_during_op", 32'(busy), 32'd1);
                check("done_low_during_op", 32'(done), 32'd0);
                check("diff_holds", 32'(diff), 32'(last_diff));
                check("borrow_holds", 32'(borrow_out), 32'(last_borrow));
                if (k == inject) begin
                    start = 1'b1;
                    a     = 8'h00;
                    b     = 8'hFF;
                end else begin
                    start = 1'b0;
                    a     = W'($urandom);
                    b     = W'($urandom);
                end
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_low_at_done", 32'(busy), 32'd0);
                check("diff_result", 32'(diff), 32'(exp_diff));
                check("borrow_result", 32'(borrow_out), 32'(exp_borrow));
                last_diff   = exp_diff;
                last_borrow = exp_borrow;
                start       = 1'b0;
            end
        end
    endtask

    // Idle cycles with start low: nothing may change.
    task automatic idle(input int n);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_diff", 32'(diff), 32'(last_diff));
            check("idle_borrow", 32'(borrow_out), 32'(last_borrow));
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b1;
        a           = 8'h35;
        b           = 8'h12;
        last_diff   = '0;
        last_borrow = 1'b0;

        // Reset held with start asserted.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst = 1'b0;
        idle(2);

        // Directed cases.
        do_op(8'h35, 8'h12, 0);
        idle(1);
        do_op(8'h12, 8'h35, 0);
        do_op(8'h00, 8'h01, 0);   // back-to-back: start in done cycle
        do_op(8'hA5, 8'hA5, 0);
        do_op(8'hFF, 8'h00, 0);
        idle(2);

        // Start while busy is ignored, then start in the done cycle is accepted.
        do_op(8'h40, 8'h01, 3);
        do_op(8'h10, 8'h20, 0);
        idle(1);

        // Reset during the 4th shift cycle aborts with no done.
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h12;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        last_diff   = '0;
        last_borrow = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        idle(W + 2);
        do_op(8'h09, 8'h03, 0);
        idle(1);

        // Randomized operations with random conflicting starts and idle gaps.
        for (int i = 0; i < 40; i++) begin
            int inj;
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : 0;
            do_op(W'($urandom), W'($urandom), inj);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
